lector_instrucciones: RTL and testbench

LECTOR_INSTRUCCIONES -- requirements
Module: lector_instrucciones

---
 rtl/lector_instrucciones_pkg.sv | 13 +
 rtl/lector_instrucciones_if.sv | 11 +
 rtl/lector_instrucciones_contador_espera.sv | 19 +
 rtl/lector_instrucciones.sv | 96 +++++++++
 tb/tb_lector_instrucciones.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lector_instrucciones_pkg.sv
// lector_instrucciones_pkg: shared widths and fetch state enumeration
package lector_instrucciones_pkg;
    localparam int ANCHO_DIR  = 14;
    localparam int ANCHO_INST = 32;
    localparam int ANCHO_MEM  = 16;
    typedef enum logic [2:0] {
        REPOSO,
        PEDIR_BAJA,
        ESPERAR_BAJA,
        PEDIR_ALTA,
        ESPERAR_ALTA
    } estado_t;
endpackage

// File: rtl/lector_instrucciones_if.sv
// lector_instrucciones_if: half-word instruction memory bus
interface lector_instrucciones_if #(
    parameter int ANCHO_DIR = lector_instrucciones_pkg::ANCHO_DIR
);
    logic                                         mem_leer;
    logic [ANCHO_DIR:0]                           mem_direccion;
    logic [lector_instrucciones_pkg::ANCHO_MEM-1:0] mem_dato;
    logic                                         mem_listo;
    modport master (output mem_leer, mem_direccion, input mem_dato, mem_listo);
    modport slave (input mem_leer, mem_direccion, output mem_dato, mem_listo);
endinterface

// File: rtl/lector_instrucciones_contador_espera.sv
// contador_espera: counts idle wait cycles and flags the cycle that reaches the limit
module contador_espera #(
    parameter int LIMITE = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic limpiar,
    input  logic habilitar,
    output logic limite_alcanzado
);
    localparam int ANCHO = $clog2(LIMITE + 1);
    logic [ANCHO-1:0] cuenta;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cuenta <= '0;
        else if (limpiar) cuenta <= '0;
        else if (habilitar) cuenta <= cuenta + 1'b1;
    // flagged while the current empty cycle is the LIMITE-th one
    assign limite_alcanzado = habilitar && (cuenta == ANCHO'(LIMITE - 1));
endmodule

// File: rtl/lector_instrucciones.sv
// lector_instrucciones: fetches a 32-bit instruction as two 16-bit half-words,
// with per-half timeout and synchronous abort
module lector_instrucciones #(
    parameter int LIMITE_ESPERA = 255,
    parameter int ANCHO_DIR     = lector_instrucciones_pkg::ANCHO_DIR
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          leer,
    input  logic [ANCHO_DIR-1:0]                          direccion,
    input  logic                                          abortar,
    lector_instrucciones_if.master                        mem,
    output logic [lector_instrucciones_pkg::ANCHO_INST-1:0] instruccion,
    output logic                                          lectura_completada,
    output logic                                          error_lectura,
    output logic                                          ocupado
);
    import lector_instrucciones_pkg::*;
    estado_t estado, siguiente;
    logic [ANCHO_DIR-1:0] dir;
    logic [ANCHO_MEM-1:0] baja;
    logic esperando, limite, cargar, capturar, completar, fallo;

    assign esperando = (estado == ESPERAR_BAJA) || (estado == ESPERAR_ALTA);
    assign ocupado = estado != REPOSO;
    assign mem.mem_leer = (estado == PEDIR_BAJA) || (estado == PEDIR_ALTA);

    contador_espera #(.LIMITE(LIMITE_ESPERA)) u_contador (
        .clk              (clk),
        .reset            (reset),
        .limpiar          (!esperando),
        .habilitar        (esperando && !mem.mem_listo),
        .limite_alcanzado (limite)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) estado <= REPOSO;
        else estado <= siguiente;

    always_comb begin
        siguiente = estado;
        cargar = 1'b0;
        capturar = 1'b0;
        completar = 1'b0;
        fallo = 1'b0;
        case (estado)
            REPOSO: begin
                cargar = leer;
                siguiente = leer ? PEDIR_BAJA : REPOSO;
            end
            PEDIR_BAJA: siguiente = ESPERAR_BAJA;
            ESPERAR_BAJA: begin
                capturar = mem.mem_listo;
                fallo = limite;
                siguiente = mem.mem_listo ? PEDIR_ALTA : (limite ? REPOSO : ESPERAR_BAJA);
            end
            PEDIR_ALTA: siguiente = ESPERAR_ALTA;
            ESPERAR_ALTA: begin
                completar = mem.mem_listo;
                fallo = limite;
                siguiente = (mem.mem_listo || limite) ? REPOSO : ESPERAR_ALTA;
            end
            default: siguiente = REPOSO;
        endcase
        if (abortar) begin
            siguiente = REPOSO;
            cargar = 1'b0;
            capturar = 1'b0;
            completar = 1'b0;
            fallo = 1'b0;
        end
    end

    // mem_direccion is loaded one edge ahead of each request so it holds between strobes
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            dir <= '0;
            baja <= '0;
            instruccion <= '0;
            mem.mem_direccion <= '0;
            lectura_completada <= 1'b0;
            error_lectura <= 1'b0;
        end else begin
            lectura_completada <= completar;
            error_lectura <= fallo;
            if (cargar) begin
                dir <= direccion;
                mem.mem_direccion <= {direccion, 1'b0};
            end
            if (capturar) begin
                baja <= mem.mem_dato;
                mem.mem_direccion <= {dir, 1'b1};
            end
            if (completar) instruccion <= {mem.mem_dato, baja};
        end
endmodule

// File: tb/tb_lector_instrucciones.sv
// tb_lector_instrucciones: directed and randomized fetches checked against a
// transaction-level model of the two-half fetch with timeout and abort
module tb_lector_instrucciones;
    localparam int LIMITE = 8;
    logic clk = 0, reset = 0, leer = 0, abortar = 0;
    logic [13:0] direccion = '0;
    logic [31:0] instruccion;
    logic lectura_completada, error_lectura, ocupado;
    int checks = 0, errors = 0;

    lector_instrucciones_if #(.ANCHO_DIR(14)) bus ();

    lector_instrucciones #(.LIMITE_ESPERA(LIMITE), .ANCHO_DIR(14)) dut (
        .clk                (clk),
        .reset              (reset),
        .leer               (leer),
        .direccion          (direccion),
        .abortar            (abortar),
        .mem                (bus),
        .instruccion        (instruccion),
        .lectura_completada (lectura_completada),
        .error_lectura      (error_lectura),
        .ocupado            (ocupado)
    );

    always #5 clk = ~clk;

    task automatic comprobar(input string nombre, input logic [31:0] obtenido, input logic [31:0] esperado);
        checks++;
        if (obtenido !== esperado) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nombre, obtenido, esperado, $time);
        end
    endtask

    // memory image and responder: answers each strobe after 'retardo' cycles (0 = never)
    logic [15:0] img [0:32767];
    int retardo = 1, cnt = 0;
    bit ruido = 0, pend = 0;
    logic [14:0] paddr = '0;
    initial begin
        bus.mem_listo = 1'b0;
        bus.mem_dato = '0;
    end
    always @(negedge clk) begin
        bus.mem_listo = 1'b0;
        bus.mem_dato = 16'($urandom);
        if (pend) begin
            if (cnt == 0) begin
                bus.mem_listo = 1'b1;
                bus.mem_dato = img[paddr];
                pend = 0;
            end else cnt--;
        end
        if (ruido && !bus.mem_listo && $urandom_range(0, 15) == 0) bus.mem_listo = 1'b1;
        if (bus.mem_leer && retardo > 0) begin
            pend = 1;
            paddr = bus.mem_direccion;
            cnt = retardo - 1;
        end
    end

    // model: m_fase -1 idle, else 2*half + (waiting ? 1 : 0)
    int m_fase = -1, m_esp = 0;
    logic [13:0] m_addr = '0;
    logic [15:0] m_low = '0;
    logic [31:0] m_inst = '0;
    logic [14:0] m_maddr = '0;
    logic m_done = 0, m_err = 0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_fase <= -1; m_esp <= 0; m_addr <= '0; m_low <= '0;
            m_inst <= '0; m_maddr <= '0; m_done <= 0; m_err <= 0;
        end else begin
            m_done <= 0;
            m_err <= 0;
            if (abortar) m_fase <= -1;
            else if (m_fase < 0) begin
                if (leer) begin
                    m_addr <= direccion;
                    m_maddr <= {direccion, 1'b0};
                    m_fase <= 0;
                end
            end else if (m_fase % 2 == 0) begin
                m_fase <= m_fase + 1;
                m_esp <= 0;
            end else if (bus.mem_listo) begin
                if (m_fase == 1) begin
                    m_low <= bus.mem_dato;
                    m_maddr <= {m_addr, 1'b1};
                    m_fase <= 2;
                end else begin
                    m_inst <= {bus.mem_dato, m_low};
                    m_done <= 1;
                    m_fase <= -1;
                end
            end else if (m_esp + 1 >= LIMITE) begin
                m_err <= 1;
                m_fase <= -1;
            end else m_esp <= m_esp + 1;
        end
    end

    always @(negedge clk) if (reset) begin
        comprobar("ocupado", 32'(ocupado), 32'(m_fase >= 0));
        comprobar("mem_leer", 32'(bus.mem_leer), 32'(m_fase == 0 || m_fase == 2));
        comprobar("mem_direccion", 32'(bus.mem_direccion), 32'(m_maddr));
        comprobar("instruccion", instruccion, m_inst);
        comprobar("lectura_completada", 32'(lectura_completada), 32'(m_done));
        comprobar("error_lectura", 32'(error_lectura), 32'(m_err));
    end

    task automatic paso();
        @(negedge clk);
        #1;
    endtask

    task automatic buscar(input logic [13:0] a, input bit mantener, input logic [13:0] b,
                          output int n, output int pulsos, output logic [14:0] d0,
                          output logic [14:0] d1, output bit fin, output bit err);
        leer = 1; direccion = a; n = 0; pulsos = 0; d0 = '0; d1 = '0; fin = 0; err = 0;
        for (int i = 1; i <= 40 && !fin && !err; i++) begin
            paso();
            if (!mantener) leer = 0;
            if (i == 2) direccion = b;
            if (bus.mem_leer) begin
                if (pulsos == 0) d0 = bus.mem_direccion;
                else d1 = bus.mem_direccion;
                pulsos++;
            end
            fin = lectura_completada;
            err = error_lectura;
            n = i;
        end
    endtask

    initial begin
        int n, pulsos;
        logic [14:0] d0, d1;
        bit fin, err, hallado;
        logic [13:0] a;
        logic [31:0] previa;
        #2000000;
        $display("FAIL watchdog: simulation did not terminate");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, pulsos;
        logic [14:0] d0, d1;
        bit fin, err, hallado;
        logic [13:0] a, b;
        logic [31:0] previa;
        for (int i = 0; i < 32768; i++) img[i] = 16'($urandom);
        img[15'h000A] = 16'h1234;
        img[15'h000B] = 16'hABCD;
        paso();
        paso();
        comprobar("reset_instruccion", instruccion, 32'h0);
        comprobar("reset_flags", {28'h0, bus.mem_leer, lectura_completada, error_lectura, ocupado}, 32'h0);
        comprobar("reset_mem_direccion", 32'(bus.mem_direccion), 32'h0);
        reset = 1;
        paso();

        // basic fetch, one-cycle memory
        buscar(14'h0005, 0, 14'h0005, n, pulsos, d0, d1, fin, err);
        comprobar("t1_fin", 32'(fin), 32'h1);
        comprobar("t1_latencia", 32'(n - 1), 32'd4);
        comprobar("t1_dir_baja", 32'(d0), 32'h000A);
        comprobar("t1_dir_alta", 32'(d1), 32'h000B);
        comprobar("t1_instruccion", instruccion, 32'hABCD1234);
        paso();
        comprobar("t1_pulso_unico", 32'(lectura_completada), 32'h0);

        // three-cycle memory
        retardo = 3;
        buscar(14'h0005, 0, 14'h0005, n, pulsos, d0, d1, fin, err);
        comprobar("t2_fin", 32'(fin), 32'h1);
        comprobar("t2_pulsos", 32'(pulsos), 32'd2);
        comprobar("t2_instruccion", instruccion, 32'hABCD1234);
        paso();

        // memory never answers
        retardo = 0;
        buscar(14'h0123, 0, 14'h0123, n, pulsos, d0, d1, fin, err);
        comprobar("t3_error", 32'(err), 32'h1);
        comprobar("t3_ciclos", 32'(n), 32'd10);
        comprobar("t3_sin_fin", 32'(fin), 32'h0);
        comprobar("t3_instruccion", instruccion, 32'hABCD1234);
        comprobar("t3_ocupado", 32'(ocupado), 32'h0);
        paso();

        // abort in ESPERAR_ALTA while the high half arrives
        retardo = 2;
        a = 14'(($urandom % 16000) + 100);
        previa = instruccion;
        leer = 1; direccion = a;
        paso();
        leer = 0;
        hallado = 0;
        for (int i = 0; i < 20 && !hallado; i++) begin
            if (m_fase == 3 && bus.mem_listo) hallado = 1;
            else paso();
        end
        comprobar("t4_preparado", 32'(hallado), 32'h1);
        abortar = 1;
        paso();
        abortar = 0;
        comprobar("t4_ocupado", 32'(ocupado), 32'h0);
        comprobar("t4_sin_fin", {30'h0, lectura_completada, error_lectura}, 32'h0);
        comprobar("t4_instruccion", instruccion, previa);
        retardo = 1;
        buscar(14'h0000, 0, 14'h0000, n, pulsos, d0, d1, fin, err);
        comprobar("t4_fin_dir0", 32'(fin), 32'h1);
        comprobar("t4_instruccion_dir0", instruccion, {img[1], img[0]});

        // leer held, address changed mid-fetch
        a = 14'h2A5C;
        b = a ^ 14'h0155;
        buscar(a, 1, b, n, pulsos, d0, d1, fin, err);
        comprobar("t5_fin", 32'(fin), 32'h1);
        comprobar("t5_dir_baja", 32'(d0), 32'({a, 1'b0}));
        comprobar("t5_instruccion", instruccion, {img[{a, 1'b1}], img[{a, 1'b0}]});
        paso();
        leer = 0;
        comprobar("t5_siguiente_leer", 32'(bus.mem_leer), 32'h1);
        comprobar("t5_siguiente_dir", 32'(bus.mem_direccion), 32'({b, 1'b0}));
        for (int i = 0; i < 40 && ocupado; i++) paso();

        // asynchronous reset during PEDIR_ALTA
        leer = 1; direccion = 14'h0777;
        paso();
        leer = 0;
        hallado = 0;
        for (int i = 0; i < 20 && !hallado; i++) begin
            if (m_fase == 2) hallado = 1;
            else paso();
        end
        comprobar("t6_preparado", 32'(hallado), 32'h1);
        reset = 0;
        #1;
        comprobar("t6_instruccion", instruccion, 32'h0);
        comprobar("t6_flags", {28'h0, bus.mem_leer, lectura_completada, error_lectura, ocupado}, 32'h0);
        comprobar("t6_mem_direccion", 32'(bus.mem_direccion), 32'h0);
        paso();
        reset = 1;
        paso();
        paso();
        comprobar("t6_reposo", 32'(ocupado), 32'h0);

        // randomized traffic with noise, timeouts, aborts and occasional resets
        ruido = 1;
        for (int c = 0; c < 3000; c++) begin
            paso();
            leer = $urandom_range(0, 3) == 0;
            direccion = 14'($urandom);
            abortar = $urandom_range(0, 40) == 0;
            if ($urandom_range(0, 20) == 0) retardo = int'($urandom_range(0, 11));
            if ($urandom_range(0, 600) == 0) begin
                reset = 0;
                paso();
                reset = 1;
            end
        end
        abortar = 0;
        leer = 0;
        paso();
        paso();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
